// File: rtl/thermo_sense.sv
// Temperature conditioning: hysteresis compare, consecutive-sample debounce and stalled-sensor timeout.
// Optional 4-sample moving average on the input when THERMO_SENSE_AVG_EN is defined.
module thermo_sense #(
  parameter int TEMP_W   = 10,
  parameter int HYST_W   = 6,
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     temp_valid,
  input  logic signed [TEMP_W-1:0] temp_data,
  input  logic signed [TEMP_W-1:0] setpoint,
  input  logic        [HYST_W-1:0] hyst,
  output logic                     too_hot,
  output logic                     too_cold,
  output logic                     sensor_fault,
  output logic                     state_change
);

  localparam int EW = TEMP_W + 2;
  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);
  localparam logic [TW-1:0] TO_C  = TW'(TIMEOUT);

  typedef enum logic [1:0] {ST_OK = 2'd0, ST_HOT = 2'd1, ST_COLD = 2'd2} state_t;

  state_t          state_r, state_s, pend_r, pend_s, target_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [TW-1:0]   to_r, to_s;
  logic            fault_r, fault_s, to_hit_s;
  logic            too_hot_r, too_cold_r, chg_r;
  logic signed [EW-1:0] sp_s, hi_s, lo_s, t_s;

  assign sp_s = EW'(setpoint);
  assign hi_s = sp_s + $signed({{(EW-HYST_W){1'b0}}, hyst});
  assign lo_s = sp_s - $signed({{(EW-HYST_W){1'b0}}, hyst});

`ifdef THERMO_SENSE_AVG_EN
  logic signed [TEMP_W-1:0] tap_r [3];
  logic                     fill_r;
  logic signed [EW-1:0]     sum_s;

  // Window sum; a fresh window counts the current sample four times
  always_comb begin
    if (fill_r) begin
      sum_s = EW'(temp_data) <<< 2;
    end else begin
      sum_s = EW'(temp_data) + EW'(tap_r[0]) + EW'(tap_r[1]) + EW'(tap_r[2]);
    end
  end

  assign t_s = sum_s >>> 2;

  // Sample history; refilled on the first sample after reset or a sensor timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_r <= 1'b1;
      for (int i = 0; i < 3; i++) tap_r[i] <= '0;
    end else if (temp_valid) begin
      fill_r   <= 1'b0;
      tap_r[0] <= temp_data;
      tap_r[1] <= fill_r ? temp_data : tap_r[0];
      tap_r[2] <= fill_r ? temp_data : tap_r[1];
    end else if (to_hit_s) begin
      fill_r <= 1'b1;
    end else begin
      fill_r <= fill_r;
    end
  end
`else
  assign t_s = EW'(temp_data);
`endif

  // Target state, debounce and timeout next-state logic
  always_comb begin
    state_s  = state_r;
    pend_s   = pend_r;
    cnt_s    = cnt_r;
    to_s     = to_r;
    fault_s  = fault_r;
    to_hit_s = 1'b0;
    case (state_r)
      ST_HOT: begin
        if (t_s < lo_s)       target_s = ST_COLD;
        else if (t_s <= sp_s) target_s = ST_OK;
        else                  target_s = ST_HOT;
      end
      ST_COLD: begin
        if (t_s > hi_s)       target_s = ST_HOT;
        else if (t_s >= sp_s) target_s = ST_OK;
        else                  target_s = ST_COLD;
      end
      default: begin
        if (t_s > hi_s)       target_s = ST_HOT;
        else if (t_s < lo_s)  target_s = ST_COLD;
        else                  target_s = ST_OK;
      end
    endcase

    if (temp_valid) begin
      to_s    = '0;
      fault_s = 1'b0;
      if (target_s == state_r) begin
        cnt_s = '0;
      end else if (target_s == pend_r && cnt_r != '0) begin
        cnt_s = cnt_r + CW'(1);
      end else begin
        pend_s = target_s;
        cnt_s  = CW'(1);
      end
      if (cnt_s == DEB_C) begin
        state_s = target_s;
        cnt_s   = '0;
      end else begin
        state_s = state_r;
      end
    end else if (to_r != TO_C) begin
      to_s = to_r + TW'(1);
      // Counter saturates at TIMEOUT so the fault event fires exactly once
      if (to_s == TO_C) begin
        to_hit_s = 1'b1;
        fault_s  = 1'b1;
        state_s  = ST_OK;
        cnt_s    = '0;
      end else begin
        to_hit_s = 1'b0;
      end
    end else begin
      to_s = to_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_OK;
      pend_r     <= ST_OK;
      cnt_r      <= '0;
      to_r       <= '0;
      fault_r    <= 1'b0;
      too_hot_r  <= 1'b0;
      too_cold_r <= 1'b0;
      chg_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      pend_r     <= pend_s;
      cnt_r      <= cnt_s;
      to_r       <= to_s;
      fault_r    <= fault_s;
      too_hot_r  <= (state_s == ST_HOT);
      too_cold_r <= (state_s == ST_COLD);
      chg_r      <= (state_s != state_r);
    end
  end

  assign too_hot      = too_hot_r;
  assign too_cold     = too_cold_r;
  assign sensor_fault = fault_r;
  assign state_change = chg_r;

endmodule

// File: tb/tb_thermo_sense.sv
// Table-driven bench for thermo_sense with a scoreboard queue of expected outputs.
module tb_thermo_sense;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              temp_valid = 1'b0;
  logic signed [9:0] temp_data = 10'sd0;
  logic signed [9:0] setpoint = 10'sd200;
  logic        [5:0] hyst = 6'd10;
  logic              too_hot, too_cold, sensor_fault, state_change;

  thermo_sense #(.TEMP_W(10), .HYST_W(6), .DEBOUNCE(3), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .temp_valid(temp_valid), .temp_data(temp_data),
    .setpoint(setpoint), .hyst(hyst), .too_hot(too_hot), .too_cold(too_cold),
    .sensor_fault(sensor_fault), .state_change(state_change)
  );

  always #5 clk = ~clk;

  // exp bits: {too_hot, too_cold, sensor_fault, state_change}
  typedef struct {
    logic       rst;
    logic       v;
    int         d;
    logic [3:0] exp;
    int         idle;
  } vec_t;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hot/cold/fault/chg=%b expected %b", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    sb_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {too_hot, too_cold, sensor_fault, state_change}, e.exp);
    end
  end

  function automatic void add(input logic rst, input logic v, input int d,
                              input logic [3:0] exp, input int idle);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.exp = exp; r.idle = idle;
    tbl.push_back(r);
  endfunction

  function automatic void add_n(input int n, input int d, input logic [3:0] exp);
    for (int k = 0; k < n; k++) add(1'b0, 1'b1, d, exp, 0);
  endfunction

  initial begin
    // Reset held three cycles
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 0, 4'b0000, 0);
    // Enter HOT after three qualifying samples
    add_n(2, 211, 4'b0000);
    add_n(1, 211, 4'b1001);
    // Inside the hysteresis band HOT holds
    add_n(5, 205, 4'b1000);
    // Back to OK at setpoint
    add_n(2, 200, 4'b1000);
    add_n(1, 200, 4'b0001);
    // HOT again, then direct HOT -> COLD
    add_n(2, 211, 4'b0000);
    add_n(1, 211, 4'b1001);
    add_n(2, 185, 4'b1000);
    add_n(1, 185, 4'b0101);
    // Timeout from COLD: 999 idle cycles still COLD, 1000th raises the fault
    add(1'b0, 1'b0, 0, 4'b0100, 998);
    add(1'b0, 1'b0, 0, 4'b0011, 0);
    add(1'b0, 1'b0, 0, 4'b0010, 0);
    add(1'b0, 1'b1, 200, 4'b0000, 0);
    add(1'b0, 1'b0, 0, 4'b0000, 0);
    // Interrupted debounce restarts the count
    add_n(2, 211, 4'b0000);
    add_n(1, 205, 4'b0000);
    add_n(2, 211, 4'b0000);
    add_n(1, 211, 4'b1001);
    add_n(2, 200, 4'b1000);
    add_n(1, 200, 4'b0001);
    // Threshold is strict
    add_n(5, 210, 4'b0000);
    // Timeout while OK: fault without a state_change pulse
    add(1'b0, 1'b0, 0, 4'b0000, 998);
    add(1'b0, 1'b0, 0, 4'b0010, 0);
    add(1'b0, 1'b1, 211, 4'b0000, 0);
    add_n(1, 211, 4'b0000);
    // Reset with valid high clears the pending debounce
    add(1'b1, 1'b1, 211, 4'b0000, 0);
    add_n(2, 211, 4'b0000);
    add_n(1, 211, 4'b1001);
    // Averaging case; also never asserts with raw samples
    add(1'b1, 1'b0, 0, 4'b0000, 0);
    add_n(1, 220, 4'b0000);
    add_n(3, 200, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      sb_t e;
      repeat (tbl[i].idle) begin
        @(negedge clk);
        reset = 1'b0;
        temp_valid = 1'b0;
      end
      @(negedge clk);
      reset      = tbl[i].rst;
      temp_valid = tbl[i].v;
      temp_data  = 10'(tbl[i].d);
      e.exp  = tbl[i].exp;
      e.name = $sformatf("row%0d", i);
      sb.push_back(e);
    end
    @(negedge clk);
    reset = 1'b0;
    temp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 4'(sb.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
